// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline that splices a 32-bit
// two's-complement immediate into the I/S/B-type immediate fields of a
// RISC-V style instruction word.
//   S1 holds the raw request {imm, src, base}.
//   S2 holds the encoded word {instr_out, range_err}.
// Optional feature macro: IMM_ENCODER_RANGE_CHECK_EN
//   defined   -> range_err flags immediates that do not fit the selected
//                format, and err_count counts delivered flagged words
//                (saturating at 255).
//   undefined -> no checking logic; range_err and err_count are tied to 0.
// rst is asynchronous and active low.
module imm_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] imm_in,
    input  logic [1:0]  imm_src,
    input  logic [31:0] base_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_out,
    output logic        range_err,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        SRC_I    = 2'b00,
        SRC_S    = 2'b01,
        SRC_B    = 2'b10,
        SRC_NONE = 2'b11
    } imm_src_e;

    typedef struct packed {
        logic [31:0] imm;
        imm_src_e    src;
        logic [31:0] base;
    } req_t;

    req_t        s1_req;
    logic        s1_valid;
    logic        s2_valid;
    logic        accept;
    logic        advance;
    logic        deliver;
    logic [31:0] enc_word;
    logic        enc_err;

    // Handshake: S1 can take a new request whenever it is empty or is about
    // to hand its contents to S2 (S2 empty or draining this cycle).
    assign advance   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || (!s2_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign deliver   = s2_valid && out_ready;
    assign out_valid = s2_valid;

    // S1: capture the raw request; empties when it advances without refill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_req   <= '{imm: imm_in, src: imm_src_e'(imm_src), base: base_instr};
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Field splicing: immediate positions are overwritten, everything else
    // is passed through from the base instruction.
    always_comb begin
        enc_word = s1_req.base;
        case (s1_req.src)
            SRC_I: begin
                enc_word[31:20] = s1_req.imm[11:0];
            end
            SRC_S: begin
                enc_word[31:25] = s1_req.imm[11:5];
                enc_word[11:7]  = s1_req.imm[4:0];
            end
            SRC_B: begin
                enc_word[31]    = s1_req.imm[12];
                enc_word[30:25] = s1_req.imm[10:5];
                enc_word[11:8]  = s1_req.imm[4:1];
                enc_word[7]     = s1_req.imm[11];
            end
            default: begin
                enc_word = s1_req.base;
            end
        endcase
    end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
    logic        fits_12;
    logic        fits_13;
    logic        range_err_q;
    logic [7:0]  err_count_q;

    // A value fits an N-bit signed field when all bits from N-1 upward are
    // copies of the sign bit.
    assign fits_12 = (&s1_req.imm[31:11]) || !(|s1_req.imm[31:11]);
    assign fits_13 = (&s1_req.imm[31:12]) || !(|s1_req.imm[31:12]);

    // Range check per format; B offsets must also be even.
    always_comb begin
        enc_err = 1'b0;
        case (s1_req.src)
            SRC_I:   enc_err = !fits_12;
            SRC_S:   enc_err = !fits_12;
            SRC_B:   enc_err = !fits_13 || s1_req.imm[0];
            default: enc_err = 1'b0;
        endcase
    end

    // Error counter: bumps on each delivered flagged word, sticks at 255.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count_q <= 8'd0;
        end else if (deliver && range_err_q && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign range_err = range_err_q;
    assign err_count = err_count_q;
`else
    logic range_err_q;
    logic unused_imm_hi;

    // Without checking the upper immediate bits carry no information.
    assign unused_imm_hi = ^{s1_req.imm[31:13], range_err_q};
    assign enc_err       = 1'b0;
    assign range_err     = 1'b0;
    assign err_count     = 8'd0;
`endif

    // S2: load the encoded word when S1 advances; otherwise hold it until
    // the consumer takes it, so payload is stable under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid    <= 1'b0;
            instr_out   <= 32'h0000_0000;
            range_err_q <= 1'b0;
        end else if (advance) begin
            s2_valid    <= 1'b1;
            instr_out   <= enc_word;
            range_err_q <= enc_err;
        end else if (deliver) begin
            s2_valid    <= 1'b0;
        end
    end

endmodule
